// File: rtl/fetch_pipe_ctrl.sv
// Fetch-side pipeline control: PC register, IF/ID and ID/EX latches with
// flush/stall handling, plus saturating bubble and flush counters.
module fetch_pipe_ctrl #(
  parameter int XLEN = 32,
  parameter int CTRL_W = 16,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pc_write,
  input  logic              if_id_write,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [XLEN-1:0]   branch_target,
  input  logic [31:0]       imem_rdata,
  input  logic [CTRL_W-1:0] id_ctrl_in,
  output logic [XLEN-1:0]   pc,
  output logic [XLEN-1:0]   if_id_pc,
  output logic [31:0]       if_id_instr,
  output logic              if_id_valid,
  output logic [CTRL_W-1:0] id_ex_ctrl,
  output logic              id_ex_valid,
  output logic [31:0]       stall_count,
  output logic [31:0]       flush_count
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic [XLEN-1:0]   pc_p0;
  logic [XLEN-1:0]   ifIdPc_p1;
  logic [31:0]       ifIdInstr_p1;
  logic              vld_p1;
  logic [CTRL_W-1:0] idExCtrl_p2;
  logic              vld_p2;
  logic [31:0]       stallCnt;
  logic [31:0]       flushCnt;

  function automatic logic [31:0] satInc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // IF stage: PC register; the adder wraps naturally at XLEN bits
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_p0 <= RESET_PC;
    end else if (branch_taken) begin
      pc_p0 <= branch_target;
    end else if (pc_write) begin
      pc_p0 <= pc_p0 + XLEN'(4);
    end
  end

  // IF/ID boundary: instruction memory is combinational, so the word at pc
  // is captured on the same edge that advances pc
  always_ff @(posedge clk) begin
    if (!rst_n || branch_taken) begin
      ifIdInstr_p1 <= NOP_INSTR;
      ifIdPc_p1    <= '0;
      vld_p1       <= 1'b0;
    end else if (if_id_write) begin
      ifIdInstr_p1 <= imem_rdata;
      ifIdPc_p1    <= pc_p0;
      vld_p1       <= 1'b1;
    end
  end

  // ID/EX boundary: a flush outranks a stall, so only one counter moves
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idExCtrl_p2 <= '0;
      vld_p2      <= 1'b0;
      stallCnt    <= '0;
      flushCnt    <= '0;
    end else if (branch_taken) begin
      idExCtrl_p2 <= '0;
      vld_p2      <= 1'b0;
      flushCnt    <= satInc(flushCnt);
    end else if (stall) begin
      idExCtrl_p2 <= '0;
      vld_p2      <= 1'b0;
      stallCnt    <= satInc(stallCnt);
    end else begin
      idExCtrl_p2 <= id_ctrl_in;
      vld_p2      <= vld_p1;
    end
  end

  assign pc          = pc_p0;
  assign if_id_pc    = ifIdPc_p1;
  assign if_id_instr = ifIdInstr_p1;
  assign if_id_valid = vld_p1;
  assign id_ex_ctrl  = idExCtrl_p2;
  assign id_ex_valid = vld_p2;
  assign stall_count = stallCnt;
  assign flush_count = flushCnt;

endmodule

// File: tb/tb_fetch_pipe_ctrl.sv
// Directed testbench for fetch_pipe_ctrl; inputs change and outputs are
// sampled on the falling clock edge.
module tb_fetch_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        pcWrite = 1'b0;
  logic        ifIdWrite = 1'b0;
  logic        stall = 1'b0;
  logic        branchTaken = 1'b0;
  logic [31:0] branchTarget = 32'h0;
  logic [31:0] imemRdata;
  logic [15:0] idCtrlIn = 16'h5A5A;
  logic [31:0] pc, ifIdPc, ifIdInstr, stallCount, flushCount;
  logic        ifIdValid, idExValid;
  logic [15:0] idExCtrl;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Instruction memory model: the word encodes its own address
  assign imemRdata = 32'hA000_0000 | pc;

  fetch_pipe_ctrl dut (
    .clk(clk), .rst_n(rstN), .pc_write(pcWrite), .if_id_write(ifIdWrite),
    .stall(stall), .branch_taken(branchTaken), .branch_target(branchTarget),
    .imem_rdata(imemRdata), .id_ctrl_in(idCtrlIn), .pc(pc), .if_id_pc(ifIdPc),
    .if_id_instr(ifIdInstr), .if_id_valid(ifIdValid), .id_ex_ctrl(idExCtrl),
    .id_ex_valid(idExValid), .stall_count(stallCount), .flush_count(flushCount)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive(input logic r, input logic bt, input logic st,
                       input logic pw, input logic iw);
    rstN = r; branchTaken = bt; stall = st; pcWrite = pw; ifIdWrite = iw;
  endtask

  task automatic doReset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    branchTarget = 32'h0000_0ABC;
    step();
    tests++; if (pc !== 32'h0) begin fails++; $display("FAIL reset_pc got %h exp %h", pc, 32'h0); end
    tests++; if (ifIdInstr !== 32'h13) begin fails++; $display("FAIL reset_instr got %h exp %h", ifIdInstr, 32'h13); end
    tests++; if (ifIdPc !== 32'h0) begin fails++; $display("FAIL reset_ifidpc got %h exp %h", ifIdPc, 32'h0); end
    tests++; if (ifIdValid !== 1'b0) begin fails++; $display("FAIL reset_ifidvalid got %b exp 0", ifIdValid); end
    tests++; if (idExCtrl !== 16'h0) begin fails++; $display("FAIL reset_ctrl got %h exp 0", idExCtrl); end
    tests++; if (idExValid !== 1'b0) begin fails++; $display("FAIL reset_idexvalid got %b exp 0", idExValid); end
    tests++; if (stallCount !== 32'h0) begin fails++; $display("FAIL reset_stallcnt got %h exp 0", stallCount); end
    tests++; if (flushCount !== 32'h0) begin fails++; $display("FAIL reset_flushcnt got %h exp 0", flushCount); end
  endtask

  task automatic test_straight_line();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    tests++; if (pc !== 32'd4) begin fails++; $display("FAIL straight_pc1 got %h exp %h", pc, 32'd4); end
    tests++; if (ifIdPc !== 32'd0) begin fails++; $display("FAIL straight_ifidpc1 got %h exp %h", ifIdPc, 32'd0); end
    tests++; if (ifIdInstr !== 32'hA000_0000) begin fails++; $display("FAIL straight_instr1 got %h exp %h", ifIdInstr, 32'hA000_0000); end
    tests++; if (ifIdValid !== 1'b1) begin fails++; $display("FAIL straight_valid1 got %b exp 1", ifIdValid); end
    tests++; if (idExValid !== 1'b0) begin fails++; $display("FAIL straight_idexvalid1 got %b exp 0", idExValid); end
    tests++; if (idExCtrl !== 16'h5A5A) begin fails++; $display("FAIL straight_ctrl1 got %h exp 5a5a", idExCtrl); end
    step();
    tests++; if (pc !== 32'd8) begin fails++; $display("FAIL straight_pc2 got %h exp %h", pc, 32'd8); end
    tests++; if (ifIdPc !== 32'd4) begin fails++; $display("FAIL straight_ifidpc2 got %h exp %h", ifIdPc, 32'd4); end
    tests++; if (idExValid !== 1'b1) begin fails++; $display("FAIL straight_idexvalid2 got %b exp 1", idExValid); end
    step();
    tests++; if (pc !== 32'd12) begin fails++; $display("FAIL straight_pc3 got %h exp %h", pc, 32'd12); end
    tests++; if (ifIdInstr !== 32'hA000_0008) begin fails++; $display("FAIL straight_instr3 got %h exp %h", ifIdInstr, 32'hA000_0008); end
  endtask

  task automatic test_load_use_stall();
    doReset();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step(); step();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    tests++; if (pc !== 32'd8) begin fails++; $display("FAIL stall_pc got %h exp %h", pc, 32'd8); end
    tests++; if (ifIdInstr !== 32'hA000_0004) begin fails++; $display("FAIL stall_instr got %h exp %h", ifIdInstr, 32'hA000_0004); end
    tests++; if (ifIdPc !== 32'd4) begin fails++; $display("FAIL stall_ifidpc got %h exp %h", ifIdPc, 32'd4); end
    tests++; if (idExValid !== 1'b0) begin fails++; $display("FAIL stall_idexvalid got %b exp 0", idExValid); end
    tests++; if (idExCtrl !== 16'h0) begin fails++; $display("FAIL stall_ctrl got %h exp 0", idExCtrl); end
    tests++; if (stallCount !== 32'd1) begin fails++; $display("FAIL stall_cnt got %h exp 1", stallCount); end
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    tests++; if (pc !== 32'd12) begin fails++; $display("FAIL stall_resume_pc got %h exp %h", pc, 32'd12); end
    tests++; if (ifIdPc !== 32'd8) begin fails++; $display("FAIL stall_resume_ifidpc got %h exp %h", ifIdPc, 32'd8); end
    tests++; if (idExValid !== 1'b1) begin fails++; $display("FAIL stall_resume_idexvalid got %b exp 1", idExValid); end
    tests++; if (stallCount !== 32'd1) begin fails++; $display("FAIL stall_resume_cnt got %h exp 1", stallCount); end
  endtask

  task automatic test_flush();
    branchTarget = 32'h100;
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    step();
    tests++; if (pc !== 32'h100) begin fails++; $display("FAIL flush_pc got %h exp %h", pc, 32'h100); end
    tests++; if (ifIdInstr !== 32'h13) begin fails++; $display("FAIL flush_instr got %h exp %h", ifIdInstr, 32'h13); end
    tests++; if (ifIdPc !== 32'h0) begin fails++; $display("FAIL flush_ifidpc got %h exp 0", ifIdPc); end
    tests++; if (ifIdValid !== 1'b0) begin fails++; $display("FAIL flush_ifidvalid got %b exp 0", ifIdValid); end
    tests++; if (idExValid !== 1'b0) begin fails++; $display("FAIL flush_idexvalid got %b exp 0", idExValid); end
    tests++; if (idExCtrl !== 16'h0) begin fails++; $display("FAIL flush_ctrl got %h exp 0", idExCtrl); end
    tests++; if (flushCount !== 32'd1) begin fails++; $display("FAIL flush_cnt got %h exp 1", flushCount); end
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    tests++; if (pc !== 32'h104) begin fails++; $display("FAIL flush_next_pc got %h exp %h", pc, 32'h104); end
    tests++; if (ifIdPc !== 32'h100) begin fails++; $display("FAIL flush_next_ifidpc got %h exp %h", ifIdPc, 32'h100); end
    tests++; if (idExValid !== 1'b0) begin fails++; $display("FAIL flush_next_idexvalid got %b exp 0", idExValid); end
    step();
    tests++; if (idExValid !== 1'b1) begin fails++; $display("FAIL flush_next2_idexvalid got %b exp 1", idExValid); end
  endtask

  task automatic test_simultaneous();
    branchTarget = 32'h200;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    tests++; if (pc !== 32'h200) begin fails++; $display("FAIL simul_pc got %h exp %h", pc, 32'h200); end
    tests++; if (flushCount !== 32'd2) begin fails++; $display("FAIL simul_flushcnt got %h exp 2", flushCount); end
    tests++; if (stallCount !== 32'd1) begin fails++; $display("FAIL simul_stallcnt got %h exp 1", stallCount); end
    tests++; if (ifIdValid !== 1'b0) begin fails++; $display("FAIL simul_ifidvalid got %b exp 0", ifIdValid); end
  endtask

  task automatic test_independent();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    step();
    tests++; if (pc !== 32'h204) begin fails++; $display("FAIL indep_pc got %h exp %h", pc, 32'h204); end
    tests++; if (ifIdPc !== 32'h200) begin fails++; $display("FAIL indep_ifidpc got %h exp %h", ifIdPc, 32'h200); end
    tests++; if (idExValid !== 1'b0) begin fails++; $display("FAIL indep_idexvalid got %b exp 0", idExValid); end
    tests++; if (stallCount !== 32'd2) begin fails++; $display("FAIL indep_stallcnt got %h exp 2", stallCount); end
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    tests++; if (pc !== 32'h208) begin fails++; $display("FAIL indep2_pc got %h exp %h", pc, 32'h208); end
    tests++; if (ifIdPc !== 32'h200) begin fails++; $display("FAIL indep2_ifidpc got %h exp %h", ifIdPc, 32'h200); end
    tests++; if (idExValid !== 1'b1) begin fails++; $display("FAIL indep2_idexvalid got %b exp 1", idExValid); end
  endtask

  task automatic test_wrap();
    branchTarget = 32'hFFFF_FFFC;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    tests++; if (pc !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_load_pc got %h exp %h", pc, 32'hFFFF_FFFC); end
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    tests++; if (pc !== 32'h0) begin fails++; $display("FAIL wrap_pc got %h exp 0", pc); end
    tests++; if (ifIdPc !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_ifidpc got %h exp %h", ifIdPc, 32'hFFFF_FFFC); end
    tests++; if (flushCount !== 32'd3) begin fails++; $display("FAIL wrap_flushcnt got %h exp 3", flushCount); end
  endtask

  task automatic test_saturation();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    force dut.stallCnt = 32'hFFFF_FFFE;
    #1;
    release dut.stallCnt;
    step();
    tests++; if (stallCount !== 32'hFFFF_FFFF) begin fails++; $display("FAIL sat_reach got %h exp ffffffff", stallCount); end
    step();
    tests++; if (stallCount !== 32'hFFFF_FFFF) begin fails++; $display("FAIL sat_hold got %h exp ffffffff", stallCount); end
    step();
    tests++; if (stallCount !== 32'hFFFF_FFFF) begin fails++; $display("FAIL sat_hold2 got %h exp ffffffff", stallCount); end
  endtask

  task automatic test_reset_mid_stall();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    tests++; if (pc !== 32'd4) begin fails++; $display("FAIL midstall_pc got %h exp %h", pc, 32'd4); end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    #2;
    tests++; if (pc !== 32'd4) begin fails++; $display("FAIL sync_reset_pc got %h exp %h", pc, 32'd4); end
    tests++; if (stallCount !== 32'hFFFF_FFFF) begin fails++; $display("FAIL sync_reset_cnt got %h exp ffffffff", stallCount); end
    step();
    tests++; if (pc !== 32'h0) begin fails++; $display("FAIL midrst_pc got %h exp 0", pc); end
    tests++; if (ifIdInstr !== 32'h13) begin fails++; $display("FAIL midrst_instr got %h exp 13", ifIdInstr); end
    tests++; if (ifIdValid !== 1'b0) begin fails++; $display("FAIL midrst_ifidvalid got %b exp 0", ifIdValid); end
    tests++; if (idExValid !== 1'b0) begin fails++; $display("FAIL midrst_idexvalid got %b exp 0", idExValid); end
    tests++; if (stallCount !== 32'h0) begin fails++; $display("FAIL midrst_stallcnt got %h exp 0", stallCount); end
    tests++; if (flushCount !== 32'h0) begin fails++; $display("FAIL midrst_flushcnt got %h exp 0", flushCount); end
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    tests++; if (pc !== 32'd4) begin fails++; $display("FAIL release_pc got %h exp %h", pc, 32'd4); end
    tests++; if (ifIdPc !== 32'h0) begin fails++; $display("FAIL release_ifidpc got %h exp 0", ifIdPc); end
    tests++; if (ifIdValid !== 1'b1) begin fails++; $display("FAIL release_ifidvalid got %b exp 1", ifIdValid); end
  endtask

  initial begin
    step();
    test_reset();
    test_straight_line();
    test_load_use_stall();
    test_flush();
    test_simultaneous();
    test_independent();
    test_wrap();
    test_saturation();
    test_reset_mid_stall();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_pipe_ctrl.md
FETCH_PIPE_CTRL -- requirements
Module: fetch_pipe_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath and PC width.
REQ-002 SHALL have parameter CTRL_W, default 16, width of the decoded ID-stage control word.
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000, fetch address after reset.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-006 SHALL have port pc_write  input  1  PC update enable from the hazard unit.
REQ-007 SHALL have port if_id_write  input  1  IF/ID register load enable from the hazard unit.
REQ-008 SHALL have port stall  input  1  load-use stall; inserts a bubble into ID/EX.
REQ-009 SHALL have port branch_taken  input  1  taken branch or jump resolved in EX; flush request.
REQ-010 SHALL have port branch_target  input  XLEN  redirect address, valid when branch_taken=1.
REQ-011 SHALL have port imem_rdata  input  32  instruction read combinationally at pc.
REQ-012 SHALL have port id_ctrl_in  input  CTRL_W  decoded control word of the IF/ID instruction.
REQ-013 SHALL have port pc  output  XLEN  current fetch address, registered.
REQ-014 SHALL have port if_id_pc  output  XLEN  PC of the instruction held in IF/ID.
REQ-015 SHALL have port if_id_instr  output  32  instruction held in IF/ID.
REQ-016 SHALL have port if_id_valid  output  1  IF/ID holds a real instruction.
REQ-017 SHALL have port id_ex_ctrl  output  CTRL_W  control word latched into ID/EX.
REQ-018 SHALL have port id_ex_valid  output  1  ID/EX holds a real instruction, not a bubble.
REQ-019 SHALL have port stall_count  output  32  number of bubble cycles inserted.
REQ-020 SHALL have port flush_count  output  32  number of flush cycles.

Function
REQ-021 SHALL resolve each edge with priority: rst_n=0 > branch_taken=1 > stall, pc_write and if_id_write as given.
REQ-022 SHALL, on branch_taken=1, load pc<=branch_target regardless of pc_write.
REQ-023 SHALL, on branch_taken=1, load if_id_instr<=32'h0000_0013 (NOP), if_id_pc<=0 and if_id_valid<=0.
REQ-024 SHALL, on branch_taken=1, load id_ex_ctrl<=0 and id_ex_valid<=0, and increment flush_count.
REQ-025 SHALL, without branch_taken, load pc<=pc+4 when pc_write=1 and hold pc when pc_write=0.
REQ-026 SHALL compute pc+4 modulo 2^XLEN, so that pc=32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-027 SHALL, without branch_taken, load if_id_instr<=imem_rdata, if_id_pc<=pc and if_id_valid<=1 when if_id_write=1, and hold all three when if_id_write=0.
REQ-028 SHALL, without branch_taken, load id_ex_ctrl<=0 and id_ex_valid<=0 when stall=1, and increment stall_count.
REQ-029 SHALL, without branch_taken and with stall=0, load id_ex_ctrl<=id_ctrl_in and id_ex_valid<=if_id_valid.
REQ-030 SHALL honour stall, pc_write and if_id_write independently, with no consistency check; for example, stall=1 with pc_write=1 still bubbles ID/EX and advances pc.
REQ-031 SHALL not increment stall_count when branch_taken=1 and stall=1 occur together; only flush_count increments.
REQ-032 SHALL saturate both counters at 32'hFFFF_FFFF with no wrap.
REQ-033 SHALL have zero-cycle instruction latency: imem_rdata for pc is captured at the same edge that advances pc.
REQ-034 SHALL have every output driven directly from a register, with no combinational input-to-output path.

Reset
REQ-035 SHALL, at a rising edge with rst_n=0, load pc<=RESET_PC, if_id_instr<=32'h0000_0013, if_id_pc<=0, if_id_valid<=0, id_ex_ctrl<=0, id_ex_valid<=0, stall_count<=0 and flush_count<=0.
REQ-036 SHALL give reset priority over all other inputs, including when asserted mid-stall or mid-flush; the first edge with rst_n=1 resumes normal operation from RESET_PC.
REQ-037 SHALL not change any state while rst_n=0 without a clock edge, since reset is synchronous.

Verification
REQ-038 SHALL cover straight-line fetch: reset, then pc_write=if_id_write=1 and stall=0 for 3 cycles -> pc sequence 0, 4, 8, 12; if_id_pc lags pc by one cycle; if_id_valid=1 from cycle 2.
REQ-039 SHALL cover a load-use stall: stall=1, pc_write=0, if_id_write=0 for 1 cycle at pc=8 -> pc holds 8; if_id_instr holds; id_ex_valid=0 and id_ex_ctrl=0 for one cycle; stall_count=1.
REQ-040 SHALL cover a flush: branch_taken=1, branch_target=32'h100 -> next cycle pc=32'h100, if_id_instr=32'h13, if_id_valid=0, id_ex_valid=0, flush_count=1.
REQ-041 SHALL cover simultaneous events: branch_taken=1 with stall=1 and pc_write=0 -> pc=branch_target, flush_count increments, stall_count unchanged.
REQ-042 SHALL cover wrap and saturation: pc forced to 32'hFFFF_FFFC with pc_write=1 -> pc=0; stall_count preloaded to 32'hFFFF_FFFF with stall=1 -> count remains 32'hFFFF_FFFF.
REQ-043 SHALL cover reset mid-stall: rst_n=0 during stall=1 -> next edge shows all REQ-035 values; a release edge followed by a normal cycle gives pc=RESET_PC+4.
